// File: rtl/carrier_wipeoff_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : carrier_wipeoff_accum_if
// Description : Sample stream, control and I/Q result bundle for the
//               carrier wipe-off integrate-and-dump accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface carrier_wipeoff_accum_if #(
    parameter int SAMPLE_WIDTH = 3,
    parameter int ACC_WIDTH    = 16,
    parameter int CNT_WIDTH    = 12
);
    logic                           enable;
    logic                           sample_valid;
    logic signed [SAMPLE_WIDTH-1:0] sample;
    logic signed [SAMPLE_WIDTH-1:0] sine;
    logic signed [SAMPLE_WIDTH-1:0] cosine;
    logic        [CNT_WIDTH-1:0]    dump_len;
    logic                           iq_ready;
    logic                           overrun_clr;
    logic                           iq_valid;
    logic signed [ACC_WIDTH-1:0]    i_sum;
    logic signed [ACC_WIDTH-1:0]    q_sum;
    logic                           overrun;

    // Source side: drives samples and control, consumes results.
    modport master (
        output enable, sample_valid, sample, sine, cosine, dump_len,
        output iq_ready, overrun_clr,
        input  iq_valid, i_sum, q_sum, overrun
    );

    // Accumulator side.
    modport slave (
        input  enable, sample_valid, sample, sine, cosine, dump_len,
        input  iq_ready, overrun_clr,
        output iq_valid, i_sum, q_sum, overrun
    );
endinterface
`default_nettype wire

// File: rtl/carrier_wipeoff_accum.sv
`default_nettype none
// ============================================================================
// Module      : carrier_wipeoff_accum
// Description : Mixes IF samples with NCO sine/cosine and integrates I/Q with
//               saturation, dumping a result every dump_len accepted samples.
// Revision    : 1.0 - initial release
// ============================================================================
module carrier_wipeoff_accum #(
    parameter int SAMPLE_WIDTH = 3,
    parameter int ACC_WIDTH    = 16,
    parameter int CNT_WIDTH    = 12
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    carrier_wipeoff_accum_if.slave bus
);

    localparam int c_PROD_W = 2 * SAMPLE_WIDTH;
    localparam int c_EXT_W  = ((ACC_WIDTH > c_PROD_W) ? ACC_WIDTH : c_PROD_W) + 1;

    logic signed [ACC_WIDTH-1:0] r_acc_i;
    logic signed [ACC_WIDTH-1:0] r_acc_q;
    logic        [CNT_WIDTH-1:0] r_cnt;
    logic        [CNT_WIDTH-1:0] r_len;
    logic signed [ACC_WIDTH-1:0] r_i_sum;
    logic signed [ACC_WIDTH-1:0] r_q_sum;
    logic                        r_valid;
    logic                        r_overrun;

    logic                        w_accept;
    logic signed [c_PROD_W-1:0]  w_pi;
    logic signed [c_PROD_W-1:0]  w_pq;
    logic signed [c_EXT_W-1:0]   w_sum_i;
    logic signed [c_EXT_W-1:0]   w_sum_q;
    logic signed [ACC_WIDTH-1:0] w_sat_i;
    logic signed [ACC_WIDTH-1:0] w_sat_q;
    logic        [CNT_WIDTH-1:0] w_len_eff;
    logic                        w_dump;
    logic                        w_ovr_set;

    function automatic logic signed [ACC_WIDTH-1:0] f_sat(input logic signed [c_EXT_W-1:0] v);
        logic [c_EXT_W-ACC_WIDTH:0] top;
        top = v[c_EXT_W-1:ACC_WIDTH-1];
        if ((top == '0) || (top == '1))
            return v[ACC_WIDTH-1:0];
        else if (v[c_EXT_W-1])
            return {1'b1, {(ACC_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(ACC_WIDTH-1){1'b1}}};
    endfunction

    assign w_accept = bus.enable && bus.sample_valid;

    // Operands are sign-extended to the product width so the full product fits.
    assign w_pi = c_PROD_W'(bus.sample) * c_PROD_W'(bus.cosine);
    assign w_pq = -(c_PROD_W'(bus.sample) * c_PROD_W'(bus.sine));

    assign w_sum_i = c_EXT_W'(r_acc_i) + c_EXT_W'(w_pi);
    assign w_sum_q = c_EXT_W'(r_acc_q) + c_EXT_W'(w_pq);
    assign w_sat_i = f_sat(w_sum_i);
    assign w_sat_q = f_sat(w_sum_q);

    // The first sample of a period uses the live dump_len; later ones the latched copy.
    assign w_len_eff = (r_cnt == '0) ? ((bus.dump_len == '0) ? CNT_WIDTH'(1) : bus.dump_len)
                                     : r_len;
    assign w_dump    = w_accept && (r_cnt == (w_len_eff - CNT_WIDTH'(1)));
    assign w_ovr_set = w_dump && r_valid && !bus.iq_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else if (!bus.enable) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_cnt   <= '0;
        end else if (bus.sample_valid) begin
            if (r_cnt == '0)
                r_len <= w_len_eff;
            if (w_dump) begin
                r_acc_i <= '0;
                r_acc_q <= '0;
                r_cnt   <= '0;
            end else begin
                r_acc_i <= w_sat_i;
                r_acc_q <= w_sat_q;
                r_cnt   <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i_sum   <= '0;
            r_q_sum   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_dump) begin
                r_i_sum <= w_sat_i;
                r_q_sum <= w_sat_q;
                r_valid <= 1'b1;
            end else if (r_valid && bus.iq_ready) begin
                r_valid <= 1'b0;
            end

            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (bus.overrun_clr)
                r_overrun <= 1'b0;
        end
    end

    assign bus.iq_valid = r_valid;
    assign bus.i_sum    = r_i_sum;
    assign bus.q_sum    = r_q_sum;
    assign bus.overrun  = r_overrun;

endmodule
`default_nettype wire

// File: doc/carrier_wipeoff_accum.md
CARRIER_WIPEOFF_ACCUM -- requirements
Module: carrier_wipeoff_accum

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 3, signed width of IF sample, sine and cosine inputs.
REQ-002 Parameter ACC_WIDTH, default 16, signed width of each I/Q accumulator and output sum.
REQ-003 Parameter CNT_WIDTH, default 12, width of dump length and sample counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  integration enable.
REQ-007 sample_valid  input  1  sample, sine and cosine are valid this cycle.
REQ-008 sample  input  SAMPLE_WIDTH  signed IF sample.
REQ-009 sine  input  SAMPLE_WIDTH  signed NCO sine, already aligned with sample.
REQ-010 cosine  input  SAMPLE_WIDTH  signed NCO cosine, already aligned with sample.
REQ-011 dump_len  input  CNT_WIDTH  samples per integration period.
REQ-012 iq_ready  input  1  consumer accepts the result.
REQ-013 overrun_clr  input  1  clears the overrun flag.
REQ-014 iq_valid  output  1  i_sum/q_sum hold an unconsumed result.
REQ-015 i_sum  output  ACC_WIDTH  signed in-phase integrated result.
REQ-016 q_sum  output  ACC_WIDTH  signed quadrature integrated result.
REQ-017 overrun  output  1  sticky flag: an unconsumed result was overwritten.

Function
REQ-018 An accepted sample occurs on a cycle with enable=1 and sample_valid=1; the block SHALL ignore all other cycles for accumulation.
REQ-019 Products SHALL be full precision (2*SAMPLE_WIDTH bits signed): pi = sample*cosine, pq = -(sample*sine).
REQ-020 On each accepted sample, acc_i SHALL become sat(acc_i+pi) and acc_q SHALL become sat(acc_q+pq), saturating to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
REQ-021 dump_len SHALL be latched on the first accepted sample of each period; a latched value of 0 SHALL be treated as 1.
REQ-022 The counter SHALL increment per accepted sample; on the accepted sample where count = latched_len-1 (the dump sample), the block SHALL load i_sum/q_sum with the saturated sums including that sample, clear the accumulators and counter to 0, and set iq_valid the following cycle (1-cycle latency).
REQ-023 i_sum, q_sum and iq_valid SHALL be held stable while iq_valid=1 and iq_ready=0.
REQ-024 iq_valid SHALL clear the cycle after iq_valid=1 and iq_ready=1 unless a dump occurs in the same cycle.
REQ-025 Dump and handshake in the same cycle: the new result SHALL load, iq_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-026 Dump while iq_valid=1 and iq_ready=0: the new result SHALL overwrite i_sum/q_sum, iq_valid SHALL stay 1, and overrun SHALL be set.
REQ-027 overrun SHALL clear on overrun_clr=1; a simultaneous set condition SHALL take priority over the clear.
REQ-028 enable=0 SHALL clear the accumulators and counter the next cycle; a pending output result and its handshake SHALL be unaffected.
REQ-029 Accumulation SHALL continue across the output handshake without any lost samples (no stall or backpressure to the sample stream).

Reset
REQ-030 While reset_n=0, the following SHALL be 0: acc_i, acc_q, counter, latched_len, i_sum, q_sum, iq_valid and overrun.
REQ-031 Reset asserted mid-period SHALL discard partial sums; after release, counting SHALL restart at the first accepted sample.

Verification
REQ-032 dump_len=4; sample=1, cosine=3, sine=2 for 4 accepted samples -> i_sum=12, q_sum=-8, iq_valid=1 one cycle after the 4th sample.
REQ-033 ACC_WIDTH=8, dump_len=16; sample=-4, cosine=-4, sine=-4 -> i_sum=127 (saturated), q_sum=-128.
REQ-034 dump_len=2, iq_ready=0 across two dumps (values 6 then 10) -> i_sum=10, overrun=1; overrun_clr=1 pulse -> overrun=0.
REQ-035 iq_ready=1 on the same cycle as the next dump -> iq_valid continuously 1, new value presented, overrun=0.
REQ-036 reset_n pulse after 3 of 4 samples, then 4 samples of product 2 -> i_sum=8 (no residue).
REQ-037 enable=0 for 1 cycle mid-period, then dump_len=0 -> counter cleared, subsequent dump on every accepted sample.
